// File: rtl/imm_gen_pipe.sv
// =============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined RISC-V immediate generator for the decode stage.
//            Decodes I/S/B/U/J and shift-amount immediates from a 32-bit
//            instruction and extends them to XLEN. Results then pass
//            through STAGES register stages with valid/ready flow control.
//            An opaque tag travels alongside each result.
// Ports    : clk, rst (sync, active-low), flush (sync clear of in-flight data)
//            in_valid/in_ready, instr[31:0], Immsrc[2:0], tag_in[TAG_W-1:0]
//            out_valid/out_ready, imm_op[XLEN-1:0], err, tag_out[TAG_W-1:0]
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module imm_gen_pipe #(
    parameter int XLEN   = 32,   // 32 or 64
    parameter int STAGES = 2,    // 1..4
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       Immsrc,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_op,
    output logic             err,
    output logic [TAG_W-1:0] tag_out
);

    // Immsrc format codes (011 is a legacy alias of the I format)
    localparam logic [2:0] c_SRC_I     = 3'b000;
    localparam logic [2:0] c_SRC_S     = 3'b001;
    localparam logic [2:0] c_SRC_B     = 3'b010;
    localparam logic [2:0] c_SRC_I_ALT = 3'b011;
    localparam logic [2:0] c_SRC_U     = 3'b100;
    localparam logic [2:0] c_SRC_J     = 3'b101;
    localparam logic [2:0] c_SRC_SHAMT = 3'b110;
    localparam logic [2:0] c_SRC_ILL   = 3'b111;

    // RV64 shift amounts are 6 bits wide, RV32 ones are 5 bits
    localparam bit c_SHAMT6 = (XLEN == 64);

    // -------------------------------------------------------------------------
    // Combinational decode ahead of stage 0
    // -------------------------------------------------------------------------
    logic [31:0]     w_sext32;
    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic            w_shamt_hi;
    logic            w_unused_opcode;

    // The opcode field never contributes to an immediate
    assign w_unused_opcode = ^instr[6:0];
    assign w_shamt_hi      = c_SHAMT6 ? instr[25] : 1'b0;

    always_comb begin
        w_sext32 = '0;
        case (Immsrc)
            c_SRC_I, c_SRC_I_ALT:
                w_sext32 = {{20{instr[31]}}, instr[31:20]};
            c_SRC_S:
                w_sext32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            c_SRC_B:
                w_sext32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            c_SRC_U:
                w_sext32 = {instr[31:12], 12'b0};
            c_SRC_J:
                w_sext32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default:
                w_sext32 = '0;
        endcase
    end

    always_comb begin
        // Every 32-bit intermediate already carries instr[31] in bit 31,
        // so a signed widening finishes the extension for XLEN=64.
        w_imm = XLEN'($signed(w_sext32));
        w_err = 1'b0;
        if (Immsrc == c_SRC_SHAMT) begin
            w_imm      = '0;
            w_imm[5:0] = {w_shamt_hi, instr[24:20]};
        end
        if (Immsrc == c_SRC_ILL) begin
            w_imm = '0;
            w_err = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] r_vld;
    logic [XLEN-1:0]   r_imm [STAGES];
    logic [STAGES-1:0] r_err;
    logic [TAG_W-1:0]  r_tag [STAGES];

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_nvld;
    logic [XLEN-1:0]   w_nimm [STAGES];
    logic [STAGES-1:0] w_nerr;
    logic [TAG_W-1:0]  w_ntag [STAGES];

    // Stage k may advance when the consumer takes the output, or when any
    // stage from k to the end is empty (that hole lets everything behind it
    // move up). Flattening the ready chain this way keeps it free of
    // bit-to-bit dependencies inside one vector.
    genvar gk;
    generate
        for (gk = 0; gk < STAGES; gk++) begin : g_adv
            assign w_adv[gk] = out_ready | ~(&r_vld[STAGES-1:gk]);
        end
    endgenerate

    // Next-value sources: stage 0 takes the decoded input, others the
    // stage in front of them.
    always_comb begin
        w_nvld[0] = in_valid;
        w_nimm[0] = w_imm;
        w_nerr[0] = w_err;
        w_ntag[0] = tag_in;
        for (int k = 1; k < STAGES; k++) begin
            w_nvld[k] = r_vld[k-1];
            w_nimm[k] = r_imm[k-1];
            w_nerr[k] = r_err[k-1];
            w_ntag[k] = r_tag[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            r_err <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_imm[k] <= '0;
                r_tag[k] <= '0;
            end
        end else if (flush) begin
            // Drop everything in flight, including the entry offered now
            r_vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= w_nvld[k];
                    r_imm[k] <= w_nimm[k];
                    r_err[k] <= w_nerr[k];
                    r_tag[k] <= w_ntag[k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[STAGES-1];
    assign imm_op    = r_imm[STAGES-1];
    assign err       = r_err[STAGES-1];
    assign tag_out   = r_tag[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// =============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe. Four instances:
//            A (XLEN=32, STAGES=1), B (XLEN=64, STAGES=1) for the format table,
//            C (XLEN=32, STAGES=2) for back-pressure and a random scoreboard,
//            D (XLEN=32, STAGES=3) for flush and reset mid-stream.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;

    // A / B
    logic        vld_ab;
    logic        rdy_a, ov_a, err_a;
    logic [31:0] imm_a;
    logic [4:0]  tago_a;
    logic        rdy_b, ov_b, err_b;
    logic [63:0] imm_b;
    logic [4:0]  tago_b;

    // C
    logic        vld_c, rdy_c, ov_c, ordy_c, err_c;
    logic [31:0] instr_c, imm_c;
    logic [2:0]  src_c;
    logic [4:0]  tag_c, tago_c;

    // D
    logic        vld_d, rdy_d, ov_d, ordy_d, err_d, flush_d;
    logic [31:0] imm_d;
    logic [4:0]  tag_d, tago_d;

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_a (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(vld_ab), .in_ready(rdy_a),
        .instr(instr), .Immsrc(src), .tag_in(tag), .out_valid(ov_a),
        .out_ready(1'b1), .imm_op(imm_a), .err(err_a), .tag_out(tago_a));

    imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5)) u_b (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(vld_ab), .in_ready(rdy_b),
        .instr(instr), .Immsrc(src), .tag_in(tag), .out_valid(ov_b),
        .out_ready(1'b1), .imm_op(imm_b), .err(err_b), .tag_out(tago_b));

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_c (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(vld_c), .in_ready(rdy_c),
        .instr(instr_c), .Immsrc(src_c), .tag_in(tag_c), .out_valid(ov_c),
        .out_ready(ordy_c), .imm_op(imm_c), .err(err_c), .tag_out(tago_c));

    imm_gen_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_d (
        .clk(clk), .rst(rst), .flush(flush_d), .in_valid(vld_d), .in_ready(rdy_d),
        .instr(instr), .Immsrc(src), .tag_in(tag_d), .out_valid(ov_d),
        .out_ready(ordy_d), .imm_op(imm_d), .err(err_d), .tag_out(tago_d));

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference decode for XLEN=32: {err, tag, imm}
    function automatic logic [37:0] model32(input logic [31:0] ins, input logic [2:0] s,
                                            input logic [4:0] t);
        logic [31:0] v;
        logic        e;
        v = 32'd0;
        e = 1'b0;
        case (s)
            3'd0, 3'd3: v = {{20{ins[31]}}, ins[31:20]};
            3'd1:       v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2:       v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd4:       v = {ins[31:12], 12'h000};
            3'd5:       v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd6:       v = {27'd0, ins[24:20]};
            default:    e = 1'b1;
        endcase
        return {e, t, v};
    endfunction

    // Directed format table (expected values worked out by hand)
    logic [31:0] t_instr [10] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7,
                                  32'h0010006F, 32'h01F09093, 32'hFFF00093, 32'h80000013,
                                  32'h800000B7, 32'h03F09093};
    logic [2:0]  t_src   [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd4, 3'd6};
    logic [31:0] t_e32   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                  32'h00000800, 32'h0000001F, 32'h00000000, 32'hFFFFF800,
                                  32'h80000000, 32'h0000001F};
    logic [63:0] t_e64   [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                  64'h0000000012345000, 64'h0000000000000800, 64'h000000000000001F,
                                  64'h0000000000000000, 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFF80000000,
                                  64'h000000000000003F};
    logic        t_err   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nt, got, cnt, rx, tx, lat_bad, ac;
        logic [37:0] exp_sb;
        logic [37:0] q_exp [$];
        int          q_cyc [$];

        rst = 1'b0; flush_d = 1'b0;
        instr = '0; src = '0; tag = '0; vld_ab = 1'b0;
        vld_c = 1'b0; ordy_c = 1'b0; instr_c = '0; src_c = '0; tag_c = '0;
        vld_d = 1'b0; ordy_d = 1'b0; tag_d = '0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ov_a",  64'(ov_a), 64'd0);
        check("rst_imm_a", 64'(imm_a), 64'd0);
        check("rst_err_a", 64'(err_a), 64'd0);
        check("rst_tag_a", 64'(tago_a), 64'd0);
        check("rst_rdy_a", 64'(rdy_a), 64'd1);
        check("rst_ov_d",  64'(ov_d), 64'd0);
        check("rst_rdy_d", 64'(rdy_d), 64'd1);
        @(negedge clk);

        // ---- Format table, one result per cycle, STAGES=1 ----
        for (int i = 0; i < 10; i++) begin
            instr  = t_instr[i];
            src    = t_src[i];
            tag    = 5'(i + 1);
            vld_ab = 1'b1;
            @(negedge clk);
            check($sformatf("fmt%0d_ov", i),    64'(ov_a), 64'd1);
            check($sformatf("fmt%0d_imm32", i), 64'(imm_a), 64'(t_e32[i]));
            check($sformatf("fmt%0d_err32", i), 64'(err_a), 64'(t_err[i]));
            check($sformatf("fmt%0d_tag", i),   64'(tago_a), 64'(i + 1));
            check($sformatf("fmt%0d_imm64", i), imm_b, t_e64[i]);
            check($sformatf("fmt%0d_err64", i), 64'(err_b), 64'(t_err[i]));
        end
        vld_ab = 1'b0;
        @(negedge clk);
        check("fmt_idle_ov", 64'(ov_a), 64'd0);

        // ---- Back-pressure, STAGES=2 ----
        ordy_c = 1'b0;
        nt = 1;
        for (int c = 0; c < 4; c++) begin
            vld_c = 1'b1; tag_c = 5'(nt); instr_c = 32'h0; src_c = 3'd0;
            #1;
            if (vld_c && rdy_c) nt++;
            @(negedge clk);
        end
        #1;
        check("bp_accepts", 64'(nt - 1), 64'd2);
        check("bp_full_rdy", 64'(rdy_c), 64'd0);
        check("bp_stall_ov", 64'(ov_c), 64'd1);
        check("bp_stall_tag", 64'(tago_c), 64'd1);
        ordy_c = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            vld_c = (nt <= 6); tag_c = 5'(nt);
            #1;
            if (ov_c && ordy_c) begin
                check("bp_order", 64'(tago_c), 64'(got + 1));
                got++;
            end
            if (vld_c && rdy_c) nt++;
            @(negedge clk);
        end
        vld_c = 1'b0;
        check("bp_count", 64'(got), 64'd6);

        // ---- Flush mid-stream, STAGES=3 ----
        ordy_d = 1'b0;
        instr = 32'h123450B7; src = 3'd4;
        nt = 1;
        for (int c = 0; c < 10 && nt <= 3; c++) begin
            vld_d = 1'b1; tag_d = 5'(nt);
            #1;
            if (rdy_d) nt++;
            @(negedge clk);
        end
        vld_d = 1'b0;
        #1;
        check("fl_full_rdy", 64'(rdy_d), 64'd0);
        check("fl_full_ov",  64'(ov_d), 64'd1);
        check("fl_full_tag", 64'(tago_d), 64'd1);
        check("fl_full_imm", 64'(imm_d), 64'h12345000);
        flush_d = 1'b1; ordy_d = 1'b1; vld_d = 1'b1; tag_d = 5'd7;
        #1;
        check("fl_rdy", 64'(rdy_d), 64'd1);
        @(negedge clk);
        flush_d = 1'b0; vld_d = 1'b0;
        #1;
        check("fl_ov", 64'(ov_d), 64'd0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (ov_d) cnt++;
        end
        check("fl_dropped", 64'(cnt), 64'd0);

        // ---- Reset mid-stream, STAGES=3 ----
        ordy_d = 1'b0;
        nt = 9;
        @(negedge clk);
        for (int c = 0; c < 10 && nt <= 11; c++) begin
            vld_d = 1'b1; tag_d = 5'(nt);
            #1;
            if (rdy_d) nt++;
            @(negedge clk);
        end
        vld_d = 1'b0;
        #1;
        check("rs_pre_tag", 64'(tago_d), 64'd9);
        check("rs_pre_imm", 64'(imm_d), 64'h12345000);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rs_ov",  64'(ov_d), 64'd0);
        check("rs_imm", 64'(imm_d), 64'd0);
        check("rs_err", 64'(err_d), 64'd0);
        check("rs_tag", 64'(tago_d), 64'd0);
        rst = 1'b1;
        #1;
        check("rs_rdy", 64'(rdy_d), 64'd1);
        @(negedge clk);

        // ---- Random valid/ready with scoreboard, STAGES=2 ----
        rx = 0; tx = 0; lat_bad = 0;
        for (int cyc = 0; cyc < 60000 && rx < 10000; cyc++) begin
            vld_c   = (tx < 10000) && ($urandom_range(3) != 0);
            instr_c = $urandom;
            src_c   = 3'($urandom_range(7));
            tag_c   = 5'($urandom);
            ordy_c  = ($urandom_range(3) != 0);
            #1;
            if (ov_c && ordy_c) begin
                if (q_exp.size() == 0) begin
                    check("sb_spurious", 64'd1, 64'd0);
                end else begin
                    exp_sb = q_exp.pop_front();
                    ac     = q_cyc.pop_front();
                    check("sb_entry", 64'({err_c, tago_c, imm_c}), 64'(exp_sb));
                    if (cyc - ac < 2) lat_bad++;
                end
                rx++;
            end
            if (vld_c && rdy_c) begin
                q_exp.push_back(model32(instr_c, src_c, tag_c));
                q_cyc.push_back(cyc);
                tx++;
            end
            @(negedge clk);
        end
        vld_c = 1'b0;
        check("sb_count", 64'(rx), 64'd10000);
        check("sb_latency", 64'(lat_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
